// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared master command encodings, arbiter state encoding and
// default widths for the RAM arbiter slice. Rev 1.0.
package mem_pkg;

  localparam int AW_DEF  = 9;
  localparam int DW_DEF  = 16;
  localparam int RAW_DEF = 8;

  // 2'b11 is reserved and decodes as no request.
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_t;

  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// rr_pick2: combinational two-requester round-robin picker.
// gnt is the index of the winner; on a tie the requester not named by last wins. Rev 1.0.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: round-robin arbiter sharing one synchronous 256x16 RAM between
// two masters; one access per four cycles, all outputs Moore. Rev 1.0.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int RAW = RAW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     m0_cmd,
  input  logic [AW-1:0]  m0_addr,
  input  logic [DW-1:0]  m0_wdata,
  output logic           m0_ack,
  input  logic [1:0]     m1_cmd,
  input  logic [AW-1:0]  m1_addr,
  input  logic [DW-1:0]  m1_wdata,
  output logic           m1_ack,
  output logic [DW-1:0]  rdata,
  output logic [RAW-1:0] mem_addr,
  output logic           mem_write,
  output logic [DW-1:0]  mem_din,
  input  logic [DW-1:0]  mem_dout
);

  arb_state_t     state_q, state_d;
  logic           last_grant;
  logic           gnt_q;
  logic [1:0]     cmd_q;
  logic [RAW-1:0] addr_q;
  logic [DW-1:0]  wdata_q;
  logic           oor_q;
  logic [DW-1:0]  rdata_q;

  logic           pick;
  logic           pick_valid;

  rr_pick2 u_pick (
    .req   ({is_req(m1_cmd), is_req(m0_cmd)}),
    .last  (last_grant),
    .gnt   (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_write = (cmd_q == MWRITE) && !oor_q;
        state_d   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        m0_ack  = ~gnt_q;
        m1_ack  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches and the shared read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      cmd_q      <= MNONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_valid) begin
        last_grant <= pick;
        gnt_q      <= pick;
        if (pick) begin
          cmd_q   <= m1_cmd;
          addr_q  <= m1_addr[RAW-1:0];
          wdata_q <= m1_wdata;
          oor_q   <= m1_addr[AW-1];
        end else begin
          cmd_q   <= m0_cmd;
          addr_q  <= m0_addr[RAW-1:0];
          wdata_q <= m0_wdata;
          oor_q   <= m0_addr[AW-1];
        end
      end
      // mem_dout is valid here because the RAM registered it at the end of ACCESS.
      if (state_q == ST_CAPTURE && cmd_q == MREAD) begin
        rdata_q <= oor_q ? '0 : mem_dout;
      end
    end
  end

  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed bench with a behavioural 256x16 synchronous RAM.
module tb_mem_arbiter;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m0_cmd = C_NONE, m1_cmd = C_NONE;
  logic [8:0]  m0_addr = '0, m1_addr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;

  logic [15:0] ram [256];
  int          wr_total = 0;
  int          total = 0;
  int          passed = 0;
  int          wr_before;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_cmd    (m0_cmd),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m1_cmd    (m1_cmd),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_write === 1'b1) wr_total <= wr_total + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[8'h01] = 16'h1111;
    ram[8'h02] = 16'h2222;
    ram[8'h05] = 16'hABCD;
    ram[8'h40] = 16'h5A5A;

    // Reset state
    step(2);
    do_reset();
    check("rst_m0_ack", 32'(m0_ack), 32'h0);
    check("rst_m1_ack", 32'(m1_ack), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_din", 32'(mem_din), 32'h0);

    // Single m0 read: ack at cycle 3
    m0_cmd = C_READ; m0_addr = 9'h005;
    check("t1_c0_m0_ack", 32'(m0_ack), 32'h0);
    step(1);
    check("t1_c1_mem_addr", 32'(mem_addr), 32'h05);
    check("t1_c1_mem_write", 32'(mem_write), 32'h0);
    step(1);
    check("t1_c2_m0_ack", 32'(m0_ack), 32'h0);
    step(1);
    check("t1_c3_m0_ack", 32'(m0_ack), 32'h1);
    check("t1_c3_m1_ack", 32'(m1_ack), 32'h0);
    check("t1_c3_rdata", 32'(rdata), 32'hABCD);
    m0_cmd = C_NONE;
    step(1);
    check("t1_c4_m0_ack", 32'(m0_ack), 32'h0);

    // Simultaneous reads after reset: m0 first, then m1
    do_reset();
    m0_cmd = C_READ; m0_addr = 9'h001;
    m1_cmd = C_READ; m1_addr = 9'h002;
    step(3);
    check("t2_c3_m0_ack", 32'(m0_ack), 32'h1);
    check("t2_c3_m1_ack", 32'(m1_ack), 32'h0);
    check("t2_c3_rdata", 32'(rdata), 32'h1111);
    m0_cmd = C_NONE;
    step(2);
    check("t2_c5_m1_ack", 32'(m1_ack), 32'h0);
    step(2);
    check("t2_c7_m1_ack", 32'(m1_ack), 32'h1);
    check("t2_c7_m0_ack", 32'(m0_ack), 32'h0);
    check("t2_c7_rdata", 32'(rdata), 32'h2222);
    m1_cmd = C_NONE;
    step(1);

    // m1 write 0x010 <- 0x1234, then m0 reads it back
    wr_before = wr_total;
    m1_cmd = C_WRITE; m1_addr = 9'h010; m1_wdata = 16'h1234;
    check("t3_c0_mem_write", 32'(mem_write), 32'h0);
    step(1);
    check("t3_c1_mem_write", 32'(mem_write), 32'h1);
    check("t3_c1_mem_addr", 32'(mem_addr), 32'h10);
    check("t3_c1_mem_din", 32'(mem_din), 32'h1234);
    step(1);
    check("t3_c2_mem_write", 32'(mem_write), 32'h0);
    step(1);
    check("t3_c3_m1_ack", 32'(m1_ack), 32'h1);
    check("t3_c3_rdata_kept", 32'(rdata), 32'h2222);
    m1_cmd = C_NONE;
    m0_cmd = C_READ; m0_addr = 9'h010;
    step(4);
    check("t3_c7_m0_ack", 32'(m0_ack), 32'h1);
    check("t3_c7_rdata", 32'(rdata), 32'h1234);
    check("t3_write_count", 32'(wr_total - wr_before), 32'h1);
    m0_cmd = C_NONE;
    step(1);

    // Out-of-range write then read at 0x140
    wr_before = wr_total;
    m0_cmd = C_WRITE; m0_addr = 9'h140; m0_wdata = 16'hFFFF;
    step(3);
    check("t4_wr_m0_ack", 32'(m0_ack), 32'h1);
    m0_cmd = C_READ;
    step(4);
    check("t4_rd_m0_ack", 32'(m0_ack), 32'h1);
    check("t4_rd_rdata", 32'(rdata), 32'h0);
    check("t4_no_write", 32'(wr_total - wr_before), 32'h0);
    check("t4_ram40_intact", 32'(ram[8'h40]), 32'h5A5A);
    m0_cmd = C_NONE;
    step(1);

    // Continuous contention: acks alternate m0, m1, ...
    do_reset();
    m0_cmd = C_READ; m0_addr = 9'h001;
    m1_cmd = C_READ; m1_addr = 9'h002;
    for (int k = 0; k < 8; k++) begin
      step(3);
      check($sformatf("t5_g%0d_m0_ack", k), 32'(m0_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("t5_g%0d_m1_ack", k), 32'(m1_ack), (k % 2 == 0) ? 32'h0 : 32'h1);
      check($sformatf("t5_g%0d_rdata", k), 32'(rdata), (k % 2 == 0) ? 32'h1111 : 32'h2222);
      if (k == 7) begin
        m0_cmd = C_NONE;
        m1_cmd = C_NONE;
      end
      step(1);
    end

    // Reset during CAPTURE of an m0 read
    m0_cmd = C_READ; m0_addr = 9'h005;
    step(2);
    reset = 1'b1;
    step(1);
    check("t6_c3_m0_ack", 32'(m0_ack), 32'h0);
    check("t6_c3_m1_ack", 32'(m1_ack), 32'h0);
    check("t6_c3_rdata", 32'(rdata), 32'h0);
    check("t6_c3_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    step(3);
    check("t6_retry_m0_ack", 32'(m0_ack), 32'h1);
    check("t6_retry_rdata", 32'(rdata), 32'hABCD);
    m0_cmd = C_NONE;
    step(1);
    check("t6_idle_m0_ack", 32'(m0_ack), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port-per-cycle 256×16 synchronous `RAM` between two bus masters: the `cpu` and a second master such as a DMA or loader. Each master presents the codebase's `mem_cmd`/`mem_addr` style request and is stalled on a per-port `ack` handshake. The arbiter sits between the masters and the `RAM` instance in the top level, replacing the direct `cpu`→`RAM` wiring. It owns grant fairness and RAM read-latency alignment.

## Interface
- `AW`, default 9: master address width; bit `AW-1` selects RAM (0) vs. out-of-range (1).
- `DW`, default 16: data width.
- `RAW`, default 8: RAM address width.
- `clk` in 1: the single clock.
- `reset` in 1: **synchronous, active-high** reset.
- `m0_cmd` / `m1_cmd` in 2: `00` MNONE, `01` MREAD, `10` MWRITE, `11` treated as MNONE.
- `m0_addr` / `m1_addr` in AW: request address.
- `m0_wdata` / `m1_wdata` in DW: write data.
- `m0_ack` / `m1_ack` out 1: one-cycle completion pulse.
- `rdata` out DW: shared read-data register; valid during and after the `ack` pulse, until the next capture.
- `mem_addr` out RAW: to `RAM` read_address and write_address.
- `mem_write` out 1: RAM write enable.
- `mem_din` out DW: RAM write data.
- `mem_dout` in DW: RAM registered read data.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS, when any valid request is present.
  - ACCESS → CAPTURE, unconditional.
  - CAPTURE → ACK, unconditional.
  - ACK → IDLE, unconditional.
- Arbitration in IDLE:
  - If only one master is requesting, it is granted.
  - If both are requesting, the master not recorded in `last_grant` is granted (round-robin).
  - `last_grant` updates on every grant.
- On grant, the following are latched: `gnt`, `cmd`, `addr`, `wdata`, and `oor = addr[AW-1]`.
- `mem_addr` is driven from `addr[RAW-1:0]`, and `mem_din` from latched `wdata`.
- ACCESS:
  - `mem_write = (cmd==MWRITE) & ~oor`; it is low in every other state.
  - The RAM registers `mem_dout` at the edge ending ACCESS.
- CAPTURE:
  - For an in-range MREAD, `rdata` ← `mem_dout` at the edge ending CAPTURE.
  - For an out-of-range MREAD, `rdata` ← 0.
  - For MWRITE, `rdata` is unchanged.
- ACK: `m{gnt}_ack` = 1 for exactly this cycle; the other ack stays 0.
- Out-of-range requests complete normally, with no RAM write and read data 0. This prevents master deadlock. Address-mapped I/O (0x100, 0x140) stays decoded in the top level, outside this block.
- Masters hold `cmd`, `addr` and `wdata` stable from request until they see `ack`. A master must deassert `cmd` or present a new request in the cycle after `ack`. Any `cmd` seen in IDLE is a new request.

## Timing
- Reset values:
  - state IDLE, `last_grant` = 1 (m0 wins the first tie).
  - `m0_ack` = `m1_ack` = 0, `mem_write` = 0.
  - `rdata` = 0, latched `addr` / `wdata` = 0, so `mem_addr` = 0 and `mem_din` = 0.
- Latency: request seen in IDLE at cycle N gives `ack` high at cycle N+3. The next grant can occur at N+4, so there is one access per 4 cycles.
- All outputs are Moore, decoded from registered state and latches; there is no combinational path from master inputs to outputs.
- Reset mid-operation:
  - Returns to IDLE at the next edge and suppresses any pending ack.
  - A write whose ACCESS cycle coincides with reset still commits at that edge, because `mem_write` is already high.
- Simultaneous new requests from both masters while busy: both wait. They are resolved in IDLE by `last_grant`.
- A master that re-requests immediately after its ack loses to a waiting other master.

## Structure
- Shared package `mem_pkg` holds:
  - the MNONE/MREAD/MWRITE encodings, reused by `cpu` and the top level;
  - the arbiter state encoding;
  - the `AW`/`DW`/`RAW` defaults.
- Sub-module `rr_pick2`: combinational two-requester round-robin picker (`req[1:0]`, `last` → `gnt`, `valid`).
- The FSM and latches live in `mem_arbiter`.

## Test plan
- RAM[0x05] = 0xABCD; m0 MREAD 0x005 at cycle 0 → `m0_ack` at cycle 3, `rdata` = 0xABCD, `m1_ack` never asserts.
- After reset, both masters MREAD (m0 @0x01, m1 @0x02) at cycle 0 → `m0_ack` at cycle 3, then `m1_ack` at cycle 7, each with its correct `rdata`.
- m1 MWRITE 0x010 ← 0x1234, then m0 MREAD 0x010:
  - `mem_write` is high only in the ACCESS cycle, with `mem_addr` = 0x10;
  - m0 reads 0x1234.
- m0 MWRITE 0x140 ← 0xFFFF, then MREAD 0x140 → `mem_write` never high, both requests acked, read returns 0x0000.
- Both masters requesting continuously for 8 grants → acks alternate m0, m1, m0, … with no starvation.
- `reset` pulsed during the CAPTURE cycle of an m0 read → no ack, IDLE next cycle, `rdata` = 0; the following request completes normally.
